// File: rtl/ram2p_arb_pkg.sv
// Shared types for the RAM-port arbiter: FSM states, read tag, width helper.
package ram2p_arb_pkg;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  // Tag index is sized for the largest supported NREQ (8)
  localparam int TAG_IW = 3;

  typedef struct packed {
    logic              vld;
    logic [TAG_IW-1:0] idx;
  } tag_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram2p.sv
// Two-port synchronous RAM, single clock; dout returns pre-write contents.
module ram2p #(
  parameter int DEPTH = 256,
  parameter int AWID  = 8,
  parameter int DWID  = 16
) (
  input  logic            clk,
  input  logic            porta__we,
  input  logic [AWID-1:0] porta__addr,
  input  logic [DWID-1:0] porta__din,
  output logic [DWID-1:0] porta__dout,
  input  logic            portb__we,
  input  logic [AWID-1:0] portb__addr,
  input  logic [DWID-1:0] portb__din,
  output logic [DWID-1:0] portb__dout
);

  logic [DWID-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (portb__we) mem[portb__addr] <= portb__din;
    if (porta__we) mem[porta__addr] <= porta__din;
    porta__dout <= mem[porta__addr];
    portb__dout <= mem[portb__addr];
  end

endmodule

// File: rtl/ram2p_arb_rr.sv
// Combinational round-robin picker: search starts just after last_grant.
module rr_arb
  import ram2p_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   win
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = idx;
      end
    end
  end

endmodule

// File: rtl/ram2p_arb.sv
// Shares one RAM port between NREQ requesters round-robin; zero-fills the RAM
// after reset, and returns read data two edges after the grant.
module ram2p_arb
  import ram2p_arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int DEPTH          = 256,
  parameter int AWID           = 8,
  parameter int DWID           = 16,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AWID-1:0] req_addr,
  input  logic [NREQ*DWID-1:0] req_din,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DWID-1:0]      rsp_dout,
  output logic                 init_done,
  output logic                 mem__we,
  output logic [AWID-1:0]      mem__addr,
  output logic [DWID-1:0]      mem__din,
  input  logic [DWID-1:0]      mem__dout
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(DEPTH + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   win;
  logic [NREQ-1:0] grant;
  logic            hs;
  tag_t [2:1]      tag_pipe;

  rr_arb #(.NREQ(NREQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .win        (win)
  );

  assign req_ready = (state == S_RUN) ? grant : '0;
  assign hs        = |req_ready;
  assign rsp_valid = tag_pipe[2].vld ? (NREQ'(1) << tag_pipe[2].idx) : '0;
  assign rsp_dout  = mem__dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      init_done  <= (CLEAR_ON_RESET == 0);
      cnt        <= '0;
      last_grant <= IW'(NREQ - 1);
      mem__we    <= 1'b0;
      mem__addr  <= '0;
      mem__din   <= '0;
      tag_pipe   <= '0;
    end else begin
      tag_pipe[2] <= tag_pipe[1];
      tag_pipe[1] <= '0;
      mem__we     <= 1'b0;
      case (state)
        S_CLEAR: begin
          // cnt == DEPTH means the last address went out on the previous edge
          if (cnt == CW'(DEPTH)) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end else begin
            mem__we   <= 1'b1;
            mem__addr <= AWID'(cnt);
            mem__din  <= '0;
            cnt       <= cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (hs) begin
            mem__we     <= req_we[win];
            mem__addr   <= req_addr[win*AWID +: AWID];
            mem__din    <= req_din[win*DWID +: DWID];
            last_grant  <= win;
            tag_pipe[1] <= '{vld: !req_we[win], idx: TAG_IW'(win)};
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ram2p_arb.sv
// Randomised + directed bench for ram2p_arb against an access-order memory model.
module tb_ram2p_arb;
  localparam int NREQ = 4, DEPTH = 16, AWID = 4, DWID = 16;

  logic                 clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [NREQ*AWID-1:0] req_addr = '0;
  logic [NREQ*DWID-1:0] req_din = '0;
  logic [DWID-1:0]      rsp_dout, mem__din, mem__dout, pb_din = '0, pb_dout;
  logic [AWID-1:0]      mem__addr, pb_addr = '0;
  logic                 init_done, mem__we, pb_we = 1'b0;

  always #5 clk = ~clk;

  ram2p_arb #(.NREQ(NREQ), .DEPTH(DEPTH), .AWID(AWID), .DWID(DWID), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_din(req_din), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
    .init_done(init_done), .mem__we(mem__we), .mem__addr(mem__addr), .mem__din(mem__din),
    .mem__dout(mem__dout)
  );

  ram2p #(.DEPTH(DEPTH), .AWID(AWID), .DWID(DWID)) u_ram (
    .clk(clk), .porta__we(mem__we), .porta__addr(mem__addr), .porta__din(mem__din),
    .porta__dout(mem__dout), .portb__we(pb_we), .portb__addr(pb_addr), .portb__din(pb_din),
    .portb__dout(pb_dout)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // next-cycle stimulus
  logic            nx_rst = 1'b1;
  logic [NREQ-1:0] nx_valid = '0, nx_we = '0;
  logic [AWID-1:0] nx_addr [NREQ];
  logic [DWID-1:0] nx_din [NREQ];

  // model state: edges since reset release, pointer, memory image, pending reads
  typedef struct {int due; int idx; logic [DWID-1:0] dat;} rsp_t;
  rsp_t            pend[$];
  int              cyc = 0, ecnt = 0, lastg = NREQ - 1;
  logic [DWID-1:0] mm [DEPTH];
  logic            e_we = 1'b0;
  logic [AWID-1:0] e_addr = '0;
  logic [DWID-1:0] e_din = '0;

  logic [NREQ-1:0] rdy_log [int];
  logic [NREQ-1:0] rv_log [int];
  logic [DWID-1:0] rd_log [int];
  logic            we_log [int];
  logic [AWID-1:0] addr_log [int];

  task automatic model_reset();
    ecnt = 0; lastg = NREQ - 1; pend.delete();
    e_we = 1'b0; e_addr = '0; e_din = '0;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
  endtask

  task automatic step();
    int w;
    logic [NREQ-1:0] er, ev;
    logic [DWID-1:0] ed;
    @(posedge clk);
    cyc++;
    #1;
    rst = nx_rst; req_valid = nx_valid; req_we = nx_we;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AWID +: AWID] = nx_addr[i];
      req_din[i*DWID +: DWID]  = nx_din[i];
    end
    #4;
    w = -1;
    if (ecnt >= DEPTH + 1)
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (lastg + k) % NREQ;
        if (w < 0 && req_valid[j]) w = j;
      end
    er = (w >= 0) ? NREQ'(1) << w : '0;
    ev = '0; ed = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = NREQ'(1) << pend[0].idx; ed = pend[0].dat; void'(pend.pop_front());
    end
    rdy_log[cyc] = req_ready; rv_log[cyc] = rsp_valid; rd_log[cyc] = rsp_dout;
    we_log[cyc] = mem__we; addr_log[cyc] = mem__addr;
    chk("init_done", init_done, (ecnt >= DEPTH + 1));
    chk("mem_we", mem__we, e_we);
    chk("mem_addr", mem__addr, e_addr);
    chk("mem_din", mem__din, e_din);
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, ev);
    if (ev != 0) chk("rsp_dout", rsp_dout, ed);
    // predict the next edge
    if (rst) model_reset();
    else begin
      ecnt++;
      if (ecnt <= DEPTH) begin
        e_we = 1'b1; e_addr = AWID'(ecnt - 1); e_din = '0;
      end else if (w >= 0) begin
        e_we = req_we[w]; e_addr = nx_addr[w]; e_din = nx_din[w];
        lastg = w;
        if (req_we[w]) mm[nx_addr[w]] = nx_din[w];
        else pend.push_back('{due: cyc + 2, idx: w, dat: mm[nx_addr[w]]});
      end else e_we = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    nx_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int c, c1, nwe;
    logic [DWID-1:0] d;
    for (int i = 0; i < NREQ; i++) begin nx_addr[i] = '0; nx_din[i] = '0; end
    model_reset();

    // preload RAM with all-ones through portb while the block is held in reset
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1 pb_we = 1'b1; pb_addr = AWID'(i); pb_din = 16'hFFFF;
    end
    @(posedge clk); #1 pb_we = 1'b0; pb_addr = 4'd9;
    @(posedge clk); #1;
    chk("preload", pb_dout, 16'hFFFF);

    // clear sequence
    nx_rst = 1'b0;
    c = cyc + 1; nwe = 0;
    for (int k = 0; k < DEPTH + 2; k++) step();
    for (int k = 0; k < DEPTH + 2; k++) nwe += int'(we_log[c + k]);
    chk("clr_we_cnt", nwe, DEPTH);
    chk("clr_first_addr", addr_log[c + 1], 0);
    chk("clr_last_addr", addr_log[c + DEPTH], DEPTH - 1);
    chk("clr_done", init_done, 1'b1);
    chk("clr_mem9", pb_dout, 16'h0000);

    // all four requesters reading continuously
    c = cyc + 1;
    nx_valid = '1; nx_we = '0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) nx_addr[i] = AWID'($urandom_range(0, DEPTH - 1));
      step();
    end
    idle(3);
    for (int k = 0; k < 8; k++) begin
      chk("t3_grant", rdy_log[c + k], NREQ'(1) << (k % 4));
      chk("t3_rsp", rv_log[c + k + 2], NREQ'(1) << (k % 4));
      chk("t3_zero", rd_log[c + k + 2], 16'h0000);
    end

    // requester 2 writes then reads addr 5
    nx_valid = 4'b0100; nx_we = 4'b0100; nx_addr[2] = 4'd5; nx_din[2] = 16'hBEEF;
    step();
    nx_we = '0;
    step(); c1 = cyc;
    idle(3);
    chk("t2_grant", rdy_log[c1], 4'b0100);
    chk("t2_rv_early", rv_log[c1 + 1], 4'b0000);
    chk("t2_rv", rv_log[c1 + 2], 4'b0100);
    chk("t2_dout", rd_log[c1 + 2], 16'hBEEF);

    // write from 0 followed immediately by read from 1, same address
    d = DWID'($urandom);
    nx_valid = 4'b0001; nx_we = 4'b0001; nx_addr[0] = 4'd7; nx_din[0] = d;
    step();
    nx_valid = 4'b0010; nx_we = '0; nx_addr[1] = 4'd7;
    step(); c1 = cyc;
    idle(3);
    chk("t5_rv", rv_log[c1 + 2], 4'b0010);
    chk("t5_dout", rd_log[c1 + 2], {16'h0, d});

    // only requesters 1 and 3
    c = cyc + 1;
    nx_valid = 4'b1010; nx_we = '0;
    for (int k = 0; k < 8; k++) step();
    idle(3);
    for (int k = 0; k < 7; k++) chk("t4_alt", rdy_log[c + k] | rdy_log[c + k + 1], 4'b1010);

    // reset while reads are in flight
    nx_valid = 4'b0011; nx_we = '0;
    step();
    nx_rst = 1'b1;
    step(); c = cyc;
    nx_rst = 1'b0; nx_valid = '0;
    step(); step();
    chk("t6_no_rsp0", rv_log[c + 1], 4'b0000);
    chk("t6_no_rsp1", rv_log[c + 2], 4'b0000);
    chk("t6_ready0", rdy_log[c + 1], 4'b0000);
    chk("t6_restart_we", we_log[c + 2], 1'b1);
    chk("t6_restart_addr", addr_log[c + 2], 4'd0);
    idle(DEPTH);

    // random traffic with occasional reset
    for (int k = 0; k < 800; k++) begin
      nx_valid = NREQ'($urandom);
      nx_we    = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        nx_addr[i] = AWID'($urandom_range(0, DEPTH - 1));
        nx_din[i]  = DWID'($urandom);
      end
      nx_rst = ($urandom_range(0, 299) == 0);
      step();
    end
    nx_rst = 1'b0;
    idle(4);
    chk("drain", pend.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
